// File: rtl/trigger_queue_manager_pkg.sv
// Shared types and width helpers for the trigger queue manager.
// Optional watchdog feature is selected with the TRIG_TIMEOUT_EN macro.
package trig_mgr_pkg;

   // Fill sequencing states: wait for work, issue go, collect done strobes.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GO   = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of a read/write pointer into a depth-entry array.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/trigger_queue_manager_if.sv
// Bundle of trigger/readout signals between the queue manager and its environment.
// With TRIG_TIMEOUT_EN defined the watchdog outputs are carried as well.
interface trigger_queue_manager_if
   import trig_mgr_pkg::*;
#(
   parameter int FILL_W = 8,
   parameter int N_CHAN = 4,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
);
   localparam int CNT_W = cnt_w(DEPTH);

   logic              trigger;
   logic [N_CHAN-1:0] chan_en;
   logic [N_CHAN-1:0] done;
   logic [N_CHAN-1:0] go;
   logic [FILL_W-1:0] fillNum;
   logic              busy;
   logic [CNT_W-1:0]  q_count;
   logic [DROP_W-1:0] dropped;
`ifdef TRIG_TIMEOUT_EN
   logic              timeout;
   logic [N_CHAN-1:0] timeout_mask;

   // Manager side: consumes triggers and done, drives go and status.
   modport master (
      input  trigger, chan_en, done,
      output go, fillNum, busy, q_count, dropped, timeout, timeout_mask
   );

   // Environment side: trigger source and readout channels.
   modport slave (
      output trigger, chan_en, done,
      input  go, fillNum, busy, q_count, dropped, timeout, timeout_mask
   );
`else
   // Manager side: consumes triggers and done, drives go and status.
   modport master (
      input  trigger, chan_en, done,
      output go, fillNum, busy, q_count, dropped
   );

   // Environment side: trigger source and readout channels.
   modport slave (
      output trigger, chan_en, done,
      input  go, fillNum, busy, q_count, dropped
   );
`endif

endinterface

// File: rtl/trig_fifo.sv
// Pending-fill queue: DEPTH x W synchronous FIFO, asynchronous active-low reset.
// A push that arrives while full is still accepted when a pop happens in the same cycle.
module trig_fifo
   import trig_mgr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = ptr_w(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr_q];
   assign count   = count_q;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/trigger_queue_manager.sv
// Trigger queue manager: numbers trigger edges as fills, queues them, issues each fill
// to the readout channels with a one-cycle go and waits for every enabled done.
// Define TRIG_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT_CYC, timeout, timeout_mask).
module trigger_queue_manager
   import trig_mgr_pkg::*;
#(
   parameter int FILL_W = 8,
   parameter int N_CHAN = 4,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
`ifdef TRIG_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1024
`endif
)(
   input  logic                    clk,
   input  logic                    reset,
   trigger_queue_manager_if.master bus
);
   localparam int CNT_W = cnt_w(DEPTH);

   state_t            state_q, state_d;
   logic              trig_q;
   logic [FILL_W-1:0] fill_ctr_q, fill_ctr_d;
   logic [FILL_W-1:0] fill_num_q, fill_num_d;
   logic [N_CHAN-1:0] en_mask_q, en_mask_d;
   logic [N_CHAN-1:0] done_lat_q, done_lat_d;
   logic [DROP_W-1:0] dropped_q, dropped_d;
   logic [N_CHAN-1:0] go_out;

   logic              trig_edge;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FILL_W-1:0] fifo_dout;
   logic [CNT_W-1:0]  fifo_count;

`ifdef TRIG_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [N_CHAN-1:0] timeout_mask_q, timeout_mask_d;
`endif

   assign trig_edge = bus.trigger & ~trig_q;
   // The only pop is the GO cycle, which is entered only with a non-empty queue.
   assign fifo_pop  = (state_q == GO);

   trig_fifo #(
      .DEPTH (DEPTH),
      .W     (FILL_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fill_ctr_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Edge acceptance: a full queue drops the edge unless a pop frees a slot this cycle.
   always_comb begin
      fifo_push  = trig_edge & (~fifo_full | fifo_pop);
      fill_ctr_d = fill_ctr_q;
      dropped_d  = dropped_q;
      if (fifo_push) fill_ctr_d = fill_ctr_q + 1'b1;
      if (trig_edge && fifo_full && !fifo_pop && (dropped_q != '1))
         dropped_d = dropped_q + 1'b1;
   end

   // Fill sequencer: next state, go pulse, enable capture and done collection.
   always_comb begin
      state_d    = state_q;
      fill_num_d = fill_num_q;
      en_mask_d  = en_mask_q;
      done_lat_d = done_lat_q;
      go_out     = '0;
`ifdef TRIG_TIMEOUT_EN
      wait_cnt_d     = wait_cnt_q;
      timeout_d      = 1'b0;
      timeout_mask_d = timeout_mask_q;
`endif
      case (state_q)
         IDLE: begin
            // The head cannot change before GO pops it, so loading here lets
            // fillNum line up with the go pulse.
            if (!fifo_empty) begin
               state_d    = GO;
               fill_num_d = fifo_dout;
            end
         end
         GO: begin
            go_out     = bus.chan_en;
            en_mask_d  = bus.chan_en;
            done_lat_d = '0;
`ifdef TRIG_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d    = (bus.chan_en == '0) ? IDLE : WAIT;
         end
         WAIT: begin
            done_lat_d = done_lat_q | (bus.done & en_mask_q);
            if (done_lat_d == en_mask_q) state_d = IDLE;
`ifdef TRIG_TIMEOUT_EN
            else if (wait_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               state_d        = IDLE;
               timeout_d      = 1'b1;
               timeout_mask_d = en_mask_q & ~done_lat_d;
            end
            wait_cnt_d = wait_cnt_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         trig_q     <= 1'b0;
         fill_ctr_q <= '0;
         fill_num_q <= '0;
         en_mask_q  <= '0;
         done_lat_q <= '0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         trig_q     <= bus.trigger;
         fill_ctr_q <= fill_ctr_d;
         fill_num_q <= fill_num_d;
         en_mask_q  <= en_mask_d;
         done_lat_q <= done_lat_d;
         dropped_q  <= dropped_d;
      end
   end

`ifdef TRIG_TIMEOUT_EN
   // Watchdog counter and timeout report registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_q     <= '0;
         timeout_q      <= 1'b0;
         timeout_mask_q <= '0;
      end else begin
         wait_cnt_q     <= wait_cnt_d;
         timeout_q      <= timeout_d;
         timeout_mask_q <= timeout_mask_d;
      end
   end

   assign bus.timeout      = timeout_q;
   assign bus.timeout_mask = timeout_mask_q;
`endif

   assign bus.go      = go_out;
   assign bus.fillNum = fill_num_q;
   assign bus.busy    = (state_q == GO) || (state_q == WAIT);
   assign bus.q_count = fifo_count;
   assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_trigger_queue_manager.sv
// Testbench for trigger_queue_manager: directed stimulus with a go scoreboard.
// Define TRIG_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_trigger_queue_manager;
   localparam int FILL_W = 8;
   localparam int N_CHAN = 4;
   localparam int DEPTH  = 4;
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [FILL_W-1:0] fill;
      logic [N_CHAN-1:0] mask;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   trigger_queue_manager_if #(
      .FILL_W (FILL_W), .N_CHAN (N_CHAN), .DEPTH (DEPTH), .DROP_W (DROP_W)
   ) bus ();

   trigger_queue_manager #(
      .FILL_W (FILL_W), .N_CHAN (N_CHAN), .DEPTH (DEPTH), .DROP_W (DROP_W)
`ifdef TRIG_TIMEOUT_EN
      , .TIMEOUT_CYC (16)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic void chk(input string name, input longint act, input longint want);
      n_chk++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
   endfunction

   // Monitor: every go pulse is matched against the oldest expected fill.
   always @(negedge clk) begin
      if (reset && bus.go != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_go", longint'(bus.go), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("go   fill=%0d mask=%b (expected fill=%0d mask=%b)",
                     bus.fillNum, bus.go, e.fill, e.mask);
            chk("go_mask", longint'(bus.go), longint'(e.mask));
            chk("go_fill", longint'(bus.fillNum), longint'(e.fill));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      bus.trigger = 1'b0;
      bus.done    = '0;
      sb.delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // One-cycle trigger pulse followed by one low cycle (20 ns edge spacing).
   task automatic pulse(input logic [FILL_W-1:0] fill, input logic [N_CHAN-1:0] mask,
                        input bit expect_go);
      if (expect_go) sb.push_back(exp_t'{fill, mask});
      bus.trigger = 1'b1;
      tick();
      bus.trigger = 1'b0;
      tick();
   endtask

   // Wait (bounded) for a go pulse; returns the number of negedges waited.
   task automatic wait_go(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.go == '0 && n < 50);
      chk({name, "_go_seen"}, longint'(bus.go != '0), 1);
   endtask

   task automatic done_pulse(input logic [N_CHAN-1:0] m);
      bus.done = m;
      tick();
      bus.done = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.trigger = 1'b0;
      bus.chan_en = 4'hF;
      bus.done    = '0;

      // Test 1: reset state, single fill, busy drop timing.
      #2 reset = 1'b0;
      #2;
      chk("rst_go",      longint'(bus.go), 0);
      chk("rst_fillnum", longint'(bus.fillNum), 0);
      chk("rst_busy",    longint'(bus.busy), 0);
      chk("rst_qcount",  longint'(bus.q_count), 0);
      chk("rst_dropped", longint'(bus.dropped), 0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      pulse(8'd0, 4'hF, 1);
      wait_go("t1", n);
      chk("t1_latency", n, 1);
      repeat (4) tick();
      chk("t1_busy_wait", longint'(bus.busy), 1);
      done_pulse(4'hF);
      chk("t1_busy_fall", longint'(bus.busy), 0);

      // Test 2: three queued fills, staggered done, go after final done.
      do_reset();
      bus.chan_en = 4'hF;
      pulse(8'd0, 4'hF, 1);
      pulse(8'd1, 4'hF, 1);
      pulse(8'd2, 4'hF, 1);
      chk("t2_qcount", longint'(bus.q_count), 2);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            wait_go("t2", n);
            chk("t2_gap", n, 2);
            tick();
            chk("t2_qcount_k", longint'(bus.q_count), 2 - k);
         end
         done_pulse(4'b0001);
         done_pulse(4'b0010);
         done_pulse(4'b0100);
         chk("t2_busy_ch3", longint'(bus.busy), 1);
         done_pulse(4'b1000);
         chk("t2_busy_fall", longint'(bus.busy), 0);
      end

      // Test 3: overflow while the first fill is stalled.
      do_reset();
      for (int i = 0; i < 6; i++) pulse(FILL_W'(i), 4'hF, i < 5);
      chk("t3_qcount_full", longint'(bus.q_count), 4);
      chk("t3_dropped", longint'(bus.dropped), 1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            wait_go("t3", n);
            tick();
         end
         done_pulse(4'hF);
      end
      chk("t3_qcount_empty", longint'(bus.q_count), 0);
      pulse(8'd5, 4'hF, 1);
      wait_go("t3_next", n);
      chk("t3_next_fill", longint'(bus.fillNum), 5);
      tick();
      done_pulse(4'hF);

      // Test 4: 257 fills, counter wraps 255 -> 0.
      do_reset();
      for (int k = 0; k < 257; k++) begin
         pulse(FILL_W'(k % 256), 4'hF, 1);
         wait_go("t4", n);
         if (k == 255) chk("t4_fill255", longint'(bus.fillNum), 255);
         if (k == 256) chk("t4_fill_wrap", longint'(bus.fillNum), 0);
         tick();
         done_pulse(4'hF);
      end

      // Test 5: partial enable, ignored done bits, empty enable skips the fill.
      do_reset();
      bus.chan_en = 4'b0101;
      pulse(8'd0, 4'b0101, 1);
      bus.done = 4'b0101;          // same cycle as go: must be ignored
      tick();
      bus.done = '0;
      chk("t5_done_at_go", longint'(bus.busy), 1);
      bus.chan_en = 4'hF;          // mid-fill change must not matter
      done_pulse(4'b1010);
      tick();
      chk("t5_disabled_done", longint'(bus.busy), 1);
      done_pulse(4'b0101);
      chk("t5_complete", longint'(bus.busy), 0);
      bus.chan_en = 4'b0000;
      pulse(8'd1, 4'b0000, 0);
      chk("t5_skip_busy_go", longint'(bus.busy), 1);
      chk("t5_skip_go_zero", longint'(bus.go), 0);
      chk("t5_skip_fill", longint'(bus.fillNum), 1);
      tick();
      chk("t5_skip_idle", longint'(bus.busy), 0);
      bus.chan_en = 4'hF;
      pulse(8'd2, 4'hF, 1);
      wait_go("t5_after_skip", n);
      tick();
      done_pulse(4'hF);

      // Test 6: asynchronous reset during WAIT with two fills pending.
      do_reset();
      pulse(8'd0, 4'hF, 1);
      tick();
      done_pulse(4'hF);
      pulse(8'd1, 4'hF, 1);
      pulse(8'd2, 4'hF, 1);
      pulse(8'd3, 4'hF, 1);
      chk("t6_qcount_pre", longint'(bus.q_count), 2);
      chk("t6_fill_pre", longint'(bus.fillNum), 1);
      chk("t6_busy_pre", longint'(bus.busy), 1);
      #2 reset = 1'b0;
      #1;
      sb.delete();
      chk("t6_async_busy", longint'(bus.busy), 0);
      chk("t6_async_fill", longint'(bus.fillNum), 0);
      chk("t6_async_qcount", longint'(bus.q_count), 0);
      chk("t6_async_go", longint'(bus.go), 0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      pulse(8'd0, 4'hF, 1);
      wait_go("t6_restart", n);
      tick();
      done_pulse(4'hF);

`ifdef TRIG_TIMEOUT_EN
      // Watchdog: channel 2 never reports done.
      do_reset();
      chk("tmo_rst", longint'(bus.timeout), 0);
      pulse(8'd0, 4'hF, 1);
      tick();
      done_pulse(4'b1011);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.timeout == 1'b0 && n < 40);
      chk("tmo_seen", longint'(bus.timeout), 1);
      chk("tmo_mask", longint'(bus.timeout_mask), 4'b0100);
      chk("tmo_idle", longint'(bus.busy), 0);
      @(negedge clk);
      chk("tmo_pulse", longint'(bus.timeout), 0);
`endif

      tick();
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
